memfir: RTL and testbench

MEMFIR -- requirements
Module: memfir

---
 rtl/memfir.sv | 178 +++++++++++++++++
 tb/tb_memfir.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memfir.sv
// Decimating FIR filter with RAM-based sample history and coefficient store.
// One multiply-accumulate per clock; the result is rounded and saturated to 24 bits.
module memfir #(
  parameter int TAPS       = 64,
  parameter int DECIMATION = 2,
  parameter int ACC_WIDTH  = 50
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_strobe,
  input  logic signed [23:0] in_data,
  input  logic               coef_wr,
  input  logic [7:0]         coef_addr,
  input  logic signed [17:0] coef_data,
  output logic               out_strobe,
  output logic signed [23:0] out_data,
  output logic               busy,
  output logic               overrun
);

  localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);
  localparam logic [3:0] PHASE_LAST = 4'(DECIMATION - 1);

  typedef enum logic [2:0] {CLEAR, IDLE, WRITE, MAC, DRAIN, OUT} state_t;

  state_t state;
  logic [AW-1:0] cnt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [3:0] phase;
  logic drain_cnt;
  logic signed [23:0] sample;

  logic [23:0] x_mem [TAPS];
  logic [17:0] c_mem [TAPS];

  logic x_we;
  logic c_we;
  logic [AW-1:0] x_waddr;
  logic [AW-1:0] c_waddr;
  logic [23:0] x_wdata;
  logic [17:0] c_wdata;

  logic signed [23:0] x_rd;
  logic signed [17:0] c_rd;
  logic signed [41:0] prod;
  logic rd_valid;
  logic prod_valid;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] rounded;
  logic signed [ACC_WIDTH-1:0] shifted;
  logic [23:0] sat;

  // CLEAR owns both write ports; otherwise samples land in WRITE and coefficients only in IDLE.
  always_comb begin
    x_we    = 1'b0;
    c_we    = 1'b0;
    x_waddr = wr_ptr;
    c_waddr = coef_addr[AW-1:0];
    x_wdata = sample;
    c_wdata = coef_data;
    case (state)
      CLEAR: begin
        x_we    = 1'b1;
        c_we    = 1'b1;
        x_waddr = cnt;
        c_waddr = cnt;
        x_wdata = '0;
        c_wdata = '0;
      end
      IDLE:    c_we = coef_wr && ({1'b0, coef_addr} < 9'(TAPS));
      WRITE:   x_we = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (x_we) x_mem[x_waddr] <= x_wdata;
    if (c_we) c_mem[c_waddr] <= c_wdata;
    x_rd <= x_mem[rd_ptr];
    c_rd <= c_mem[cnt];
    prod <= 42'(x_rd) * 42'(c_rd);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid   <= 1'b0;
      prod_valid <= 1'b0;
      acc        <= '0;
    end else begin
      rd_valid   <= (state == MAC);
      prod_valid <= rd_valid;
      if (state == WRITE) acc <= '0;
      else if (prod_valid) acc <= acc + ACC_WIDTH'(prod);
    end
  end

  // Round half up, drop 17 fraction bits, clamp if the upper bits are not pure sign.
  always_comb begin
    rounded = acc + ACC_WIDTH'(65536);
    shifted = rounded >>> 17;
    if (&shifted[ACC_WIDTH-1:23] || ~|shifted[ACC_WIDTH-1:23]) sat = shifted[23:0];
    else sat = shifted[ACC_WIDTH-1] ? 24'h800000 : 24'h7FFFFF;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= CLEAR;
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      phase      <= '0;
      drain_cnt  <= 1'b0;
      sample     <= '0;
      out_strobe <= 1'b0;
      out_data   <= '0;
      busy       <= 1'b1;
      overrun    <= 1'b0;
    end else begin
      out_strobe <= 1'b0;
      if (in_strobe && state != IDLE) overrun <= 1'b1;
      case (state)
        CLEAR: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        IDLE: begin
          if (in_strobe) begin
            sample <= in_data;
            state  <= WRITE;
            busy   <= 1'b1;
          end
        end
        WRITE: begin
          wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
          rd_ptr <= wr_ptr;
          cnt    <= '0;
          if (phase == PHASE_LAST) begin
            phase <= '0;
            state <= MAC;
          end else begin
            phase <= phase + 4'd1;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        MAC: begin
          rd_ptr <= (rd_ptr == '0) ? LAST : rd_ptr - AW'(1);
          if (cnt == LAST) begin
            cnt       <= '0;
            drain_cnt <= 1'b0;
            state     <= DRAIN;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) state <= OUT;
        end
        OUT: begin
          out_strobe <= 1'b1;
          out_data   <= sat;
          state      <= IDLE;
          busy       <= 1'b0;
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_memfir.sv
// Bench for memfir: three instances (4 taps dec 1, 4 taps dec 2, 64 taps dec 1)
// checked against a behavioural FIR model through an output scoreboard.
module tb_memfir;

  localparam int TAPS_V [3] = '{4, 4, 64};
  localparam int DEC_V  [3] = '{1, 2, 1};

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [2:0] in_strobe_v = '0;
  logic [2:0] coef_wr_v = '0;
  logic [2:0][23:0] in_data_v = '0;
  logic [2:0][7:0] coef_addr_v = '0;
  logic [2:0][17:0] coef_data_v = '0;
  wire [2:0] out_strobe_v;
  wire [2:0] busy_v;
  wire [2:0] overrun_v;
  wire [2:0][23:0] out_data_v;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int dut;
    int value;
    int cycle;
  } exp_t;

  exp_t sb[$];
  int log_q[$];
  int hist [3][64];
  int coef_m [3][64];
  int wp_m [3];
  int ph_m [3];

  memfir #(.TAPS(4), .DECIMATION(1), .ACC_WIDTH(50)) dut_a (
    .clock(clock), .reset_n(reset_n), .in_strobe(in_strobe_v[0]), .in_data(in_data_v[0]),
    .coef_wr(coef_wr_v[0]), .coef_addr(coef_addr_v[0]), .coef_data(coef_data_v[0]),
    .out_strobe(out_strobe_v[0]), .out_data(out_data_v[0]), .busy(busy_v[0]), .overrun(overrun_v[0]));

  memfir #(.TAPS(4), .DECIMATION(2), .ACC_WIDTH(50)) dut_b (
    .clock(clock), .reset_n(reset_n), .in_strobe(in_strobe_v[1]), .in_data(in_data_v[1]),
    .coef_wr(coef_wr_v[1]), .coef_addr(coef_addr_v[1]), .coef_data(coef_data_v[1]),
    .out_strobe(out_strobe_v[1]), .out_data(out_data_v[1]), .busy(busy_v[1]), .overrun(overrun_v[1]));

  memfir #(.TAPS(64), .DECIMATION(1), .ACC_WIDTH(50)) dut_c (
    .clock(clock), .reset_n(reset_n), .in_strobe(in_strobe_v[2]), .in_data(in_data_v[2]),
    .coef_wr(coef_wr_v[2]), .coef_addr(coef_addr_v[2]), .coef_data(coef_data_v[2]),
    .out_strobe(out_strobe_v[2]), .out_data(out_data_v[2]), .busy(busy_v[2]), .overrun(overrun_v[2]));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Every out_strobe must match the oldest pending expectation in value, instance and cycle.
  always @(negedge clock) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (reset_n && out_strobe_v[d]) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_strobe dut%0d got out_data=%0d required no strobe", d, $signed(out_data_v[d]));
        end else begin
          e = sb.pop_front();
          if (e.dut != d || out_data_v[d] !== 24'(e.value) || cyc != e.cycle) begin
            errors++;
            $display("[TB] FAIL output dut%0d got value=%0d cycle=%0d required dut%0d value=%0d cycle=%0d",
                     d, $signed(out_data_v[d]), cyc, e.dut, e.value, e.cycle);
          end
        end
        log_q.push_back(int'($signed(out_data_v[d])));
      end
    end
  end

  function automatic int model_out(input int d);
    longint acc = 0;
    longint r;
    int t = TAPS_V[d];
    for (int k = 0; k < t; k++)
      acc += longint'(hist[d][(wp_m[d] - 1 - k + t) % t]) * longint'(coef_m[d][k]);
    r = (acc + 64'sd65536) >>> 17;
    if (r > 64'sd8388607) r = 64'sd8388607;
    else if (r < -64'sd8388608) r = -64'sd8388608;
    return int'(r);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic reset_model();
    for (int d = 0; d < 3; d++) begin
      wp_m[d] = 0;
      ph_m[d] = 0;
      for (int k = 0; k < 64; k++) begin
        hist[d][k] = 0;
        coef_m[d][k] = 0;
      end
    end
    sb.delete();
  endtask

  task automatic send(input int d, input int s, input bit accepted);
    in_strobe_v[d] = 1'b1;
    in_data_v[d] = 24'(s);
    if (accepted) begin
      hist[d][wp_m[d]] = s;
      wp_m[d] = (wp_m[d] + 1) % TAPS_V[d];
      if (ph_m[d] == DEC_V[d] - 1) begin
        ph_m[d] = 0;
        sb.push_back('{d, model_out(d), cyc + TAPS_V[d] + 5});
      end else begin
        ph_m[d]++;
      end
    end
    tick(1);
    in_strobe_v[d] = 1'b0;
  endtask

  task automatic write_coef(input int d, input int addr, input int val, input bit accepted);
    coef_wr_v[d] = 1'b1;
    coef_addr_v[d] = 8'(addr);
    coef_data_v[d] = 18'(val);
    if (accepted) coef_m[d][addr] = val;
    tick(1);
    coef_wr_v[d] = 1'b0;
  endtask

  task automatic load4(input int d);
    write_coef(d, 0, 65536, 1);
    write_coef(d, 1, 32768, 1);
    write_coef(d, 2, 16384, 1);
    write_coef(d, 3, 8192, 1);
  endtask

  task automatic wait_outputs(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      tick(1);
      n++;
    end
    tick(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_timeout pending=%0d required=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    int na = 0;
    int nc = 0;
    int guard = 0;
    reset_model();
    tick(3);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (busy_v[d] !== 1'b1 || out_strobe_v[d] !== 1'b0 || out_data_v[d] !== 24'd0 || overrun_v[d] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_values dut%0d got busy=%b strobe=%b data=%0d overrun=%b required 1 0 0 0",
                 d, busy_v[d], out_strobe_v[d], $signed(out_data_v[d]), overrun_v[d]);
      end
    end
    reset_n = 1'b1;
    while ((busy_v[0] || busy_v[2]) && guard < 300) begin
      @(negedge clock);
      if (busy_v[0]) na++;
      if (busy_v[2]) nc++;
      guard++;
    end
    tick(1);
    checks++;
    if (na != 4) begin
      errors++;
      $display("[TB] FAIL clear_cycles_4taps got %0d required 4", na);
    end
    checks++;
    if (nc != 64) begin
      errors++;
      $display("[TB] FAIL clear_cycles_64taps got %0d required 64", nc);
    end
  endtask

  task automatic test_impulse();
    int want [5] = '{2048, 1024, 512, 256, 0};
    load4(0);
    write_coef(0, 4, 131071, 0);
    write_coef(0, 200, -5, 0);
    log_q.delete();
    send(0, 4096, 1);
    tick(9);
    for (int i = 0; i < 5; i++) begin
      send(0, 0, 1);
      tick(9);
    end
    wait_outputs("impulse");
    checks++;
    if (log_q.size() != 6) begin
      errors++;
      $display("[TB] FAIL impulse_count got %0d required 6", log_q.size());
    end
    for (int i = 0; i < 5 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] != want[i]) begin
        errors++;
        $display("[TB] FAIL impulse_out%0d got %0d required %0d", i, log_q[i], want[i]);
      end
    end
    checks++;
    if (overrun_v[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL impulse_overrun got %b required 0", overrun_v[0]);
    end
  endtask

  task automatic test_decimation();
    load4(1);
    log_q.delete();
    for (int i = 0; i < 8; i++) begin
      send(1, 1000, 1);
      tick(9);
    end
    wait_outputs("decimation");
    checks++;
    if (log_q.size() != 4) begin
      errors++;
      $display("[TB] FAIL decim_count got %0d required 4", log_q.size());
    end
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] != ((i == 0) ? 750 : 938)) begin
        errors++;
        $display("[TB] FAIL decim_out%0d got %0d required %0d", i, log_q[i], (i == 0) ? 750 : 938);
      end
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 4; k++) write_coef(0, k, 131071, 1);
    log_q.delete();
    for (int i = 0; i < 4; i++) begin
      send(0, 8388607, 1);
      tick(9);
    end
    wait_outputs("sat_pos");
    checks++;
    if (log_q.size() == 0 || log_q[$] != 8388607) begin
      errors++;
      $display("[TB] FAIL sat_pos got %0d required 8388607", (log_q.size() == 0) ? 0 : log_q[$]);
    end
    tick(5);
    checks++;
    if (out_data_v[0] !== 24'h7FFFFF) begin
      errors++;
      $display("[TB] FAIL hold_between_strobes got %0d required 8388607", $signed(out_data_v[0]));
    end
    log_q.delete();
    for (int i = 0; i < 4; i++) begin
      send(0, -8388608, 1);
      tick(9);
    end
    wait_outputs("sat_neg");
    checks++;
    if (log_q.size() == 0 || log_q[$] != -8388608) begin
      errors++;
      $display("[TB] FAIL sat_neg got %0d required -8388608", (log_q.size() == 0) ? 0 : log_q[$]);
    end
  endtask

  task automatic test_overrun();
    load4(0);
    for (int i = 0; i < 4; i++) begin
      send(0, 0, 1);
      tick(9);
    end
    wait_outputs("overrun_flush");
    checks++;
    if (overrun_v[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overrun_before got %b required 0", overrun_v[0]);
    end
    log_q.delete();
    send(0, 4096, 1);
    send(0, 777, 0);
    tick(15);
    wait_outputs("overrun");
    checks++;
    if (overrun_v[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overrun_sticky got %b required 1", overrun_v[0]);
    end
    checks++;
    if (log_q.size() != 1 || log_q[0] != 2048) begin
      errors++;
      $display("[TB] FAIL overrun_first_only got count=%0d value=%0d required count=1 value=2048",
               log_q.size(), (log_q.size() == 0) ? 0 : log_q[0]);
    end
  endtask

  task automatic test_reset_mid_mac();
    int want [5] = '{2048, 1024, 512, 256, 0};
    int na = 0;
    int guard = 0;
    send(0, 4096, 1);
    tick(3);
    reset_n = 1'b0;
    reset_model();
    tick(2);
    checks++;
    if (busy_v[0] !== 1'b1 || out_strobe_v[0] !== 1'b0 || overrun_v[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_mac_reset got busy=%b strobe=%b overrun=%b required 1 0 0",
               busy_v[0], out_strobe_v[0], overrun_v[0]);
    end
    reset_n = 1'b1;
    while (busy_v[0] && guard < 300) begin
      @(negedge clock);
      if (busy_v[0]) na++;
      guard++;
    end
    tick(1);
    checks++;
    if (na != 4) begin
      errors++;
      $display("[TB] FAIL mid_mac_clear_cycles got %0d required 4", na);
    end
    tick(20);
    checks++;
    if (out_data_v[0] !== 24'd0) begin
      errors++;
      $display("[TB] FAIL mid_mac_no_output got %0d required 0", $signed(out_data_v[0]));
    end
    load4(0);
    log_q.delete();
    send(0, 4096, 1);
    tick(9);
    for (int i = 0; i < 4; i++) begin
      send(0, 0, 1);
      tick(9);
    end
    wait_outputs("after_reset");
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= log_q.size() || log_q[i] != want[i]) begin
        errors++;
        $display("[TB] FAIL after_reset_out%0d got %0d required %0d", i, (i < log_q.size()) ? log_q[i] : 0, want[i]);
      end
    end
  endtask

  task automatic test_long_wrap();
    int s;
    for (int k = 0; k < 64; k++) write_coef(2, k, int'($urandom_range(0, 65535)) - 32768, 1);
    log_q.delete();
    for (int i = 0; i < 200; i++) begin
      s = int'($urandom_range(0, 4194303)) - 2097152;
      if (i % 37 == 0) s = (i % 2 == 1) ? 8388607 : -8388608;
      send(2, s, 1);
      if (i == 3) begin
        write_coef(2, 5, 99999, 0);
        tick(68);
      end else begin
        tick(69);
      end
    end
    wait_outputs("long");
    checks++;
    if (log_q.size() != 200) begin
      errors++;
      $display("[TB] FAIL long_count got %0d required 200", log_q.size());
    end
    checks++;
    if (overrun_v[2] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL long_overrun got %b required 0", overrun_v[2]);
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_decimation();
    test_saturation();
    test_overrun();
    test_reset_mid_mac();
    test_long_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog got timeout required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
